// File: rtl/fwd_hazard_unit_pkg.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit_pkg
// Shared definitions for the forwarding / hazard unit:
//   - FSM state type and encodings (IDLE, LU_STALL)
//   - RISC-V register-field positions (rd, rs1, rs2, rs3)
//   - sel_w(): width of one forwarding-select field
//   - src_lsb(): bit position of source operand N inside an instruction
// -----------------------------------------------------------------------------
package fwd_hazard_unit_pkg;

    typedef logic [0:0] fsm_state_t;
    localparam fsm_state_t ST_IDLE     = 1'b0;
    localparam fsm_state_t ST_LU_STALL = 1'b1;

    localparam int REG_W   = 5;
    localparam int RD_LSB  = 7;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int RS3_LSB = 27;

    localparam int CNT_W   = 3;

    // Select value 0 is the register file, k is stage k-1.
    function automatic int sel_w(input int num_fwd);
        return $clog2(num_fwd + 1);
    endfunction

    // Source 0 = rs1, 1 = rs2, anything above = rs3.
    function automatic int src_lsb(input int idx);
        case (idx)
            0:       return RS1_LSB;
            1:       return RS2_LSB;
            default: return RS3_LSB;
        endcase
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_prio_sel.sv
// -----------------------------------------------------------------------------
// fwd_prio_sel
// Priority match of one source register against every forwarding stage.
// The youngest (lowest-index) stage that writes a non-zero rd equal to the
// source wins; no match (or source x0) selects the register file (0).
// Ports:
//   src     - source register number
//   stg_we  - per-stage register-write enable
//   stg_rd  - per-stage destination register
//   sel     - 0 = register file, k = stage k-1
// -----------------------------------------------------------------------------
module fwd_prio_sel
    import fwd_hazard_unit_pkg::*;
#(
    parameter int NUM_FWD = 2,
    parameter int SELW    = sel_w(NUM_FWD)
) (
    input  logic [REG_W-1:0]              src,
    input  logic [NUM_FWD-1:0]            stg_we,
    input  logic [NUM_FWD-1:0][REG_W-1:0] stg_rd,
    output logic [SELW-1:0]               sel
);

    // Walk oldest to youngest so the youngest match is the last one written.
    always_comb begin
        sel = '0;
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (stg_we[k] && (stg_rd[k] != '0) && (stg_rd[k] == src)) begin
                sel = SELW'(k + 1);
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit
// Operand forwarding select plus load-use / multi-cycle hazard stall.
//   FWD_SEL     - per ID/EX source (rs1, rs2[, rs3]) forwarding select
//   STALL       - hold PC and IF/ID, bubble ID/EX
// Inputs:
//   CLK, RST_N  - clock (rising edge), async active-low reset
//   IF_ID_INST  - decode instruction (load-use / scoreboard sources)
//   ID_EX_INST  - execute instruction (forwarding sources, load rd)
//   ID_EX_MEMREAD - execute instruction is a load
//   STG_REGWRITE, STG_INST - per forwarding stage write enable / instruction
//   FLUSH       - taken branch/jump; cancels the stall
//   MC_ISSUE/MC_RD, MC_DONE/MC_DONE_RD - multi-cycle op issue / retire
// Build option: define FWD_SCOREBOARD_EN to add the 32-entry busy scoreboard
// for multi-cycle ops; otherwise the MC_* inputs are ignored.
// -----------------------------------------------------------------------------
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
#(
    parameter int NUM_FWD  = 2,
    parameter int NUM_SRC  = 2,
    parameter int LOAD_LAT = 1
) (
    input  logic                                  CLK,
    input  logic                                  RST_N,
    input  logic [31:0]                           IF_ID_INST,
    input  logic [31:0]                           ID_EX_INST,
    input  logic                                  ID_EX_MEMREAD,
    input  logic [NUM_FWD-1:0]                    STG_REGWRITE,
    input  logic [NUM_FWD*32-1:0]                 STG_INST,
    input  logic                                  FLUSH,
    input  logic                                  MC_ISSUE,
    input  logic [4:0]                            MC_RD,
    input  logic                                  MC_DONE,
    input  logic [4:0]                            MC_DONE_RD,
    output logic [NUM_SRC*sel_w(NUM_FWD)-1:0]     FWD_SEL,
    output logic                                  STALL
);

    localparam int SELW = sel_w(NUM_FWD);
    // First LOAD_LAT stall cycle happens in IDLE, so the counter covers the rest.
    localparam logic [CNT_W-1:0] CNT_INIT = (LOAD_LAT > 1) ? CNT_W'(LOAD_LAT - 2) : '0;

    logic [NUM_FWD-1:0][REG_W-1:0] stg_rd;
    logic [NUM_SRC-1:0][REG_W-1:0] ex_src;
    logic [NUM_SRC-1:0][REG_W-1:0] id_src;
    logic [NUM_SRC-1:0][SELW-1:0]  fwd_sel;

    // ---------------------------------------------------------------- fields
    for (genvar k = 0; k < NUM_FWD; k++) begin : g_stg
        assign stg_rd[k] = STG_INST[k*32 + RD_LSB +: REG_W];
    end

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        assign ex_src[s] = ID_EX_INST[src_lsb(s) +: REG_W];
        assign id_src[s] = IF_ID_INST[src_lsb(s) +: REG_W];

        fwd_prio_sel #(
            .NUM_FWD (NUM_FWD),
            .SELW    (SELW)
        ) u_sel (
            .src    (ex_src[s]),
            .stg_we (STG_REGWRITE),
            .stg_rd (stg_rd),
            .sel    (fwd_sel[s])
        );
    end

    assign FWD_SEL = RST_N ? fwd_sel : '0;

    // ------------------------------------------------------ load-use detect
    logic [REG_W-1:0] ex_rd;
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             lu_hit;

    assign ex_rd  = ID_EX_INST[RD_LSB  +: REG_W];
    assign id_rs1 = IF_ID_INST[RS1_LSB +: REG_W];
    assign id_rs2 = IF_ID_INST[RS2_LSB +: REG_W];
    assign lu_hit = ID_EX_MEMREAD && (ex_rd != '0) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    // ------------------------------------------------------------ stall FSM
    fsm_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lu_stall;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lu_stall = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (lu_hit) begin
                    lu_stall = 1'b1;
                    if (LOAD_LAT > 1) begin
                        state_d = ST_LU_STALL;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            ST_LU_STALL: begin
                lu_stall = 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A redirect kills whatever the stall was protecting, including a
        // detection raised in this very cycle.
        if (FLUSH) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            lu_stall = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ----------------------------------------------------------- scoreboard
    logic sb_hit;

`ifdef FWD_SCOREBOARD_EN
    logic [31:0] busy_q, busy_d;

    // Clear before set so an issue and a retire to the same register in one
    // cycle leave the register busy (the new op still owns it).
    always_comb begin
        busy_d = busy_q;
        if (MC_DONE) begin
            busy_d[MC_DONE_RD] = 1'b0;
        end
        if (MC_ISSUE && (MC_RD != '0)) begin
            busy_d[MC_RD] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        sb_hit = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (busy_q[id_src[s]]) begin
                sb_hit = 1'b1;
            end
        end
    end

    logic unused_mc;
    assign unused_mc = 1'b0;
`else
    assign sb_hit = 1'b0;

    logic unused_mc;
    assign unused_mc = ^{MC_ISSUE, MC_RD, MC_DONE, MC_DONE_RD, id_src};
`endif

    assign STALL = RST_N && !FLUSH && (lu_stall || sb_hit);

    // Opcode/funct bits are not needed here.
    logic unused_bits;
    assign unused_bits = ^{IF_ID_INST, ID_EX_INST, STG_INST, unused_mc};

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_fwd_hazard_unit
// Directed scenarios followed by a randomized run, each cycle compared against
// a behavioural model (owed-stall-cycle count, busy-register array, linear
// search for the youngest writing stage). NUM_FWD=3, NUM_SRC=2, LOAD_LAT=3.
// Scoreboard checks follow the FWD_SCOREBOARD_EN build option.
// -----------------------------------------------------------------------------
module tb_fwd_hazard_unit;

    localparam int NF = 3;
    localparam int NS = 2;
    localparam int LL = 3;
    localparam int SW = 2;

    logic              CLK = 1'b0;
    logic              RST_N;
    logic [31:0]       IF_ID_INST;
    logic [31:0]       ID_EX_INST;
    logic              ID_EX_MEMREAD;
    logic [NF-1:0]     STG_REGWRITE;
    logic [NF*32-1:0]  STG_INST;
    logic              FLUSH;
    logic              MC_ISSUE;
    logic [4:0]        MC_RD;
    logic              MC_DONE;
    logic [4:0]        MC_DONE_RD;
    logic [NS*SW-1:0]  FWD_SEL;
    logic              STALL;

    int n_chk  = 0;
    int n_fail = 0;

    // model state
    int lu_rem = 0;     // load-use stall cycles still owed after this one
    bit busy [32];

    always #5 CLK = ~CLK;

    fwd_hazard_unit #(
        .NUM_FWD  (NF),
        .NUM_SRC  (NS),
        .LOAD_LAT (LL)
    ) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .IF_ID_INST    (IF_ID_INST),
        .ID_EX_INST    (ID_EX_INST),
        .ID_EX_MEMREAD (ID_EX_MEMREAD),
        .STG_REGWRITE  (STG_REGWRITE),
        .STG_INST      (STG_INST),
        .FLUSH         (FLUSH),
        .MC_ISSUE      (MC_ISSUE),
        .MC_RD         (MC_RD),
        .MC_DONE       (MC_DONE),
        .MC_DONE_RD    (MC_DONE_RD),
        .FWD_SEL       (FWD_SEL),
        .STALL         (STALL)
    );

    function automatic logic [31:0] mk(input int rd, input int rs1, input int rs2);
        return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), 7'h33};
    endfunction

    // ------------------------------------------------------------ the model
    function automatic int m_sel(input int s);
        int r;
        int res;
        r   = (s == 0) ? int'(ID_EX_INST[19:15]) : int'(ID_EX_INST[24:20]);
        res = 0;
        if (RST_N && r != 0) begin
            for (int k = 0; k < NF; k++) begin
                if (res == 0 && STG_REGWRITE[k] && int'(STG_INST[k*32+7 +: 5]) == r)
                    res = k + 1;
            end
        end
        return res;
    endfunction

    function automatic bit m_load_use();
        int rd;
        rd = int'(ID_EX_INST[11:7]);
        return ID_EX_MEMREAD && rd != 0 &&
               (rd == int'(IF_ID_INST[19:15]) || rd == int'(IF_ID_INST[24:20]));
    endfunction

    function automatic bit m_stall();
        bit lu;
        bit sb;
        lu = (lu_rem > 0) || m_load_use();
        sb = 1'b0;
`ifdef FWD_SCOREBOARD_EN
        sb = busy[IF_ID_INST[19:15]] || busy[IF_ID_INST[24:20]];
`endif
        return RST_N && !FLUSH && (lu || sb);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_stall"}, {31'd0, STALL}, {31'd0, m_stall()});
        for (int s = 0; s < NS; s++)
            chk($sformatf("%s_sel%0d", tag, s), {30'd0, FWD_SEL[s*SW +: SW]}, m_sel(s));
    endtask

    // Advance the model across the coming edge, then move to just past it.
    task automatic tick();
        if (!RST_N) begin
            lu_rem = 0;
            for (int i = 0; i < 32; i++) busy[i] = 1'b0;
        end else begin
            if (FLUSH)              lu_rem = 0;
            else if (lu_rem > 0)    lu_rem = lu_rem - 1;
            else if (m_load_use())  lu_rem = LL - 1;
`ifdef FWD_SCOREBOARD_EN
            if (MC_DONE) busy[MC_DONE_RD] = 1'b0;
            if (MC_ISSUE && MC_RD != 0) busy[MC_RD] = 1'b1;
`endif
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        IF_ID_INST    = '0;
        ID_EX_INST    = '0;
        ID_EX_MEMREAD = 1'b0;
        STG_REGWRITE  = '0;
        STG_INST      = '0;
        FLUSH         = 1'b0;
        MC_ISSUE      = 1'b0;
        MC_RD         = '0;
        MC_DONE       = 1'b0;
        MC_DONE_RD    = '0;
    endtask

    initial begin
        RST_N = 1'b0;
        clear_inputs();

        // ---- reset: outputs quiet even with hits on every input
        STG_REGWRITE      = 3'b001;
        STG_INST[11:7]    = 5'd5;
        ID_EX_INST        = mk(7, 5, 0);
        ID_EX_MEMREAD     = 1'b1;
        IF_ID_INST        = mk(0, 7, 0);
        #3;
        chk("rst_stall", {31'd0, STALL}, 0);
        chk("rst_sel",   {28'd0, FWD_SEL}, 0);
        tick();
        chk("rst_stall_edge", {31'd0, STALL}, 0);
        clear_inputs();
        RST_N = 1'b1;
        #1;
        check_model("post_rst");

        // ---- forwarding priority
        STG_REGWRITE       = 3'b011;
        STG_INST[11:7]     = 5'd5;
        STG_INST[43:39]    = 5'd5;
        STG_INST[75:71]    = 5'd5;
        ID_EX_INST         = mk(0, 5, 0);
        #1;
        chk("fwd_s0_wins", {30'd0, FWD_SEL[1:0]}, 1);
        check_model("fwd_a");
        STG_REGWRITE = 3'b010;
        #1;
        chk("fwd_s1", {30'd0, FWD_SEL[1:0]}, 2);
        STG_REGWRITE = 3'b100;
        #1;
        chk("fwd_s2", {30'd0, FWD_SEL[1:0]}, 3);
        ID_EX_INST = mk(0, 6, 5);
        #1;
        chk("fwd_rs2_s2", {30'd0, FWD_SEL[3:2]}, 3);
        chk("fwd_rs1_rf", {30'd0, FWD_SEL[1:0]}, 0);

        // ---- x0 never forwards
        STG_REGWRITE   = 3'b011;
        STG_INST[11:7] = 5'd0;
        STG_INST[43:39] = 5'd0;
        ID_EX_INST     = mk(0, 0, 0);
        #1;
        chk("fwd_x0_rs2", {30'd0, FWD_SEL[3:2]}, 0);
        check_model("fwd_x0");
        tick();
        clear_inputs();

        // ---- load-use, LOAD_LAT cycles
        ID_EX_INST    = mk(7, 1, 2);
        ID_EX_MEMREAD = 1'b1;
        IF_ID_INST    = mk(0, 3, 7);
        #1;
        chk("lu_c1", {31'd0, STALL}, 1);
        check_model("lu_c1");
        tick();
        ID_EX_INST    = '0;     // bubble enters ID/EX
        ID_EX_MEMREAD = 1'b0;
        chk("lu_c2", {31'd0, STALL}, 1);
        tick();
        chk("lu_c3", {31'd0, STALL}, 1);
        check_model("lu_c3");
        tick();
        chk("lu_c4", {31'd0, STALL}, 0);
        tick();
        chk("lu_c5", {31'd0, STALL}, 0);
        tick();

        // ---- flush in the second stall cycle
        ID_EX_INST    = mk(7, 0, 0);
        ID_EX_MEMREAD = 1'b1;
        IF_ID_INST    = mk(0, 0, 7);
        #1;
        chk("fl_c1", {31'd0, STALL}, 1);
        tick();
        ID_EX_INST    = '0;
        ID_EX_MEMREAD = 1'b0;
        FLUSH         = 1'b1;
        #1;
        chk("fl_c2", {31'd0, STALL}, 0);
        tick();
        FLUSH = 1'b0;
        #1;
        chk("fl_idle", {31'd0, STALL}, 0);
        check_model("fl_idle");
        tick();

        // ---- flush beats a fresh detection
        ID_EX_INST    = mk(7, 0, 0);
        ID_EX_MEMREAD = 1'b1;
        FLUSH         = 1'b1;
        #1;
        chk("fl_new", {31'd0, STALL}, 0);
        tick();
        ID_EX_INST    = '0;
        ID_EX_MEMREAD = 1'b0;
        FLUSH         = 1'b0;
        #1;
        chk("fl_new_next", {31'd0, STALL}, 0);
        tick();

        // ---- reset during LU_STALL
        ID_EX_INST    = mk(7, 0, 0);
        ID_EX_MEMREAD = 1'b1;
        IF_ID_INST    = mk(0, 7, 0);
        #1;
        tick();
        ID_EX_INST    = '0;
        ID_EX_MEMREAD = 1'b0;
        #1;
        chk("rs_in_stall", {31'd0, STALL}, 1);
        RST_N = 1'b0;
        #1;
        chk("rs_abort", {31'd0, STALL}, 0);
        tick();
        RST_N = 1'b1;
        #1;
        chk("rs_rel1", {31'd0, STALL}, 0);
        tick();
        chk("rs_rel2", {31'd0, STALL}, 0);
        tick();
        clear_inputs();

        // ---- multi-cycle scoreboard
        MC_ISSUE = 1'b1;
        MC_RD    = 5'd9;
        #1;
        chk("sb_issue", {31'd0, STALL}, 0);
        tick();
        MC_ISSUE   = 1'b0;
        IF_ID_INST = mk(0, 9, 0);
        #1;
`ifdef FWD_SCOREBOARD_EN
        chk("sb_busy1", {31'd0, STALL}, 1);
        tick();
        chk("sb_busy2", {31'd0, STALL}, 1);
        MC_DONE    = 1'b1;
        MC_DONE_RD = 5'd9;
        #1;
        chk("sb_done_cyc", {31'd0, STALL}, 1);
        tick();
        MC_DONE = 1'b0;
        chk("sb_released", {31'd0, STALL}, 0);
        // issue and retire together -> still busy
        IF_ID_INST = '0;
        MC_ISSUE   = 1'b1;
        MC_RD      = 5'd9;
        MC_DONE    = 1'b1;
        MC_DONE_RD = 5'd9;
        tick();
        MC_ISSUE   = 1'b0;
        MC_DONE    = 1'b0;
        IF_ID_INST = mk(0, 0, 9);
        #1;
        chk("sb_iss_done", {31'd0, STALL}, 1);
        FLUSH = 1'b1;
        #1;
        chk("sb_flush_mask", {31'd0, STALL}, 0);
        tick();
        FLUSH = 1'b0;
        #1;
        chk("sb_kept", {31'd0, STALL}, 1);
        MC_DONE    = 1'b1;
        MC_DONE_RD = 5'd9;
        tick();
        MC_DONE = 1'b0;
        chk("sb_clear", {31'd0, STALL}, 0);
        // x0 is never marked busy
        MC_ISSUE = 1'b1;
        MC_RD    = 5'd0;
        tick();
        MC_ISSUE   = 1'b0;
        IF_ID_INST = mk(0, 0, 0);
        #1;
        chk("sb_x0", {31'd0, STALL}, 0);
`else
        chk("sb_ignored", {31'd0, STALL}, 0);
        tick();
        chk("sb_ignored2", {31'd0, STALL}, 0);
`endif
        check_model("sb_end");
        tick();

        // ---- randomized run
        for (int c = 0; c < 600; c++) begin
            RST_N         = ($urandom_range(0, 59) != 0);
            STG_REGWRITE  = NF'($urandom);
            for (int k = 0; k < NF; k++) begin
                STG_INST[k*32 +: 32]    = $urandom;
                STG_INST[k*32+7 +: 5]   = 5'($urandom_range(0, 7));
            end
            ID_EX_INST        = $urandom;
            ID_EX_INST[11:7]  = 5'($urandom_range(0, 7));
            ID_EX_INST[19:15] = 5'($urandom_range(0, 7));
            ID_EX_INST[24:20] = 5'($urandom_range(0, 7));
            ID_EX_MEMREAD     = ($urandom_range(0, 3) == 0);
            IF_ID_INST        = $urandom;
            IF_ID_INST[19:15] = 5'($urandom_range(0, 7));
            IF_ID_INST[24:20] = 5'($urandom_range(0, 7));
            FLUSH             = ($urandom_range(0, 9) == 0);
            MC_ISSUE          = ($urandom_range(0, 5) == 0);
            MC_RD             = 5'($urandom_range(0, 7));
            MC_DONE           = ($urandom_range(0, 3) == 0);
            MC_DONE_RD        = 5'($urandom_range(0, 7));
            #1;
            check_model($sformatf("rnd%0d", c));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
